// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO mode port: mode codes, sequencer state encoding
// and the default data width.
package fifo_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD      = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_port_sequencer.sv
// Arbitrates the single FIFO mode port between a producer (writes) and a consumer
// (reads into a one-entry holding register), round-robin when both want it.
module fifo_port_sequencer
  import fifo_pkg::*;
#(
  parameter int W      = DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready,
  output logic [1:0]   fifo_mode,
  output logic [W-1:0] fifo_din,
  input  logic [W-1:0] fifo_dout,
  input  logic         fifo_empty,
  input  logic         fifo_full,
  output logic [1:0]   dbg_state
);

  // Handshakes: a word moves on a cycle where valid and ready are both high at the
  // rising edge; valid never waits on ready, and a held word stays stable until taken.

  state_t       state;
  state_t       state_d;
  logic         rr;
  logic [1:0]   wait_cnt;
  logic         wr_ok;
  logic         rd_ok;
  logic         grant_wr;
  logic         grant_rd;
  logic         capture;

  // Flags are only trusted in IDLE, where fifo_mode has been 00 for a cycle.
  assign wr_ok = s_valid & ~fifo_full;
  assign rd_ok = ~fifo_empty & (~m_valid | m_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_ok && (!rd_ok || !rr)) begin
          grant_wr = 1'b1;
          state_d  = ST_WR;
        end else if (rd_ok) begin
          grant_rd = 1'b1;
          state_d  = ST_RD;
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD:      state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (wait_cnt == 2'd0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = rst_n & grant_wr;
    capture   = (state == ST_RD_WAIT) && (wait_cnt == 2'd0);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mode <= MODE_IDLE;
      fifo_din  <= '0;
      rr        <= 1'b0;
      wait_cnt  <= 2'd0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      if (grant_wr) begin
        fifo_mode <= MODE_WRITE;
        fifo_din  <= s_data;
      end else if (grant_rd) begin
        fifo_mode <= MODE_READ;
      end else begin
        fifo_mode <= MODE_IDLE;
      end

      // Only contested grants flip the preference.
      if (state == ST_IDLE && wr_ok && rd_ok) rr <= ~rr;

      if (state == ST_RD) wait_cnt <= 2'(RD_LAT - 1);
      else if (state == ST_RD_WAIT && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;

      // rd_ok guarantees the register is free (or being emptied) by capture time.
      if (capture) begin
        m_valid <= 1'b1;
        m_data  <= fifo_dout;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
